// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops, plus an
// iterative one-bit-per-cycle shifter, launched by start and finished by a done pulse.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  ALUCtrl,
    input  logic        Branch,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        BranchTaken
);
    localparam int WIDTH = 32;

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_kind_t;

    state_t            state_q;
    shift_kind_t       kind_q;
    logic [4:0]        count_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  result_q;
    logic              busy_q, done_q, zero_q, taken_q;

    logic [WIDTH-1:0]  res_d;
    logic              taken_d;
    logic              is_shift_d;
    shift_kind_t       kind_d;
    logic [4:0]        amt_d;
    logic [WIDTH-1:0]  step_d;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        res_d      = '0;
        taken_d    = 1'b0;
        is_shift_d = 1'b0;
        kind_d     = SH_SLL;
        amt_d      = shamt;
        unique case (ALUCtrl)
            5'b00000: res_d = A & B;
            5'b00001: res_d = A | B;
            5'b01100: res_d = ~(A | B);
            5'b01101: res_d = A ^ B;
            5'b00010: res_d = A + B;
            5'b00111: res_d = {31'b0, A < B};
            5'b00110: if (Branch) taken_d = (A == B);
                      else        res_d   = A - B;
            5'b01000: if (Branch) taken_d = (A != B);
                      else        res_d   = {31'b0, $signed(A) < $signed(B)};
            5'b01001: if (Branch) taken_d = ~A[31] && (A != '0);
                      else begin is_shift_d = 1'b1; kind_d = SH_SLL; end
            5'b01010: if (Branch) taken_d = A[31] || (A == '0);
                      else begin is_shift_d = 1'b1; kind_d = SH_SRA; end
            5'b01011: begin is_shift_d = 1'b1; kind_d = SH_SRL; end
            5'b01110: begin is_shift_d = 1'b1; kind_d = SH_SLL; amt_d = A[4:0]; end
            5'b01111: begin is_shift_d = 1'b1; kind_d = SH_SRA; amt_d = A[4:0]; end
            5'b10000: begin is_shift_d = 1'b1; kind_d = SH_SRL; amt_d = A[4:0]; end
            5'b11011: taken_d = ~A[31];
            5'b11111: taken_d = A[31];
            default:  res_d = '0;
        endcase
        // A zero-amount shift completes immediately with B unchanged.
        if (is_shift_d) res_d = B;

        unique case (kind_q)
            SH_SLL:  step_d = {opnd_q[WIDTH-2:0], 1'b0};
            SH_SRL:  step_d = {1'b0, opnd_q[WIDTH-1:1]};
            SH_SRA:  step_d = {opnd_q[WIDTH-1], opnd_q[WIDTH-1:1]};
            default: step_d = opnd_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            kind_q   <= SH_SLL;
            count_q  <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    if (is_shift_d && amt_d != 5'd0) begin
                        opnd_q  <= B;
                        kind_q  <= kind_d;
                        count_q <= amt_d;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        result_q <= res_d;
                        zero_q   <= (res_d == '0);
                        taken_q  <= taken_d;
                        done_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    opnd_q  <= step_d;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        result_q <= step_d;
                        zero_q   <= (step_d == '0);
                        taken_q  <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Result      = result_q;
    assign Zero        = zero_q;
    assign BranchTaken = taken_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  ALUCtrl;
    logic        Branch;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        busy, done, Zero, BranchTaken;
    logic [31:0] Result;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .start(start), .ALUCtrl(ALUCtrl), .Branch(Branch),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .Result(Result), .Zero(Zero), .BranchTaken(BranchTaken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drives the operation and start now, then returns 1ns after edge t.
    task automatic launch(input logic [4:0] op, input logic br, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        ALUCtrl = op; Branch = br; A = a; B = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after t until done rises; bounded.
    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic single(input string tag, input logic [4:0] op, input logic br,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_taken);
        launch(op, br, a, b, 5'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_res"}, Result, exp_res);
        check({tag, "_taken"}, {31'b0, BranchTaken}, {31'b0, exp_taken});
    endtask

    initial begin
        int n, busy_cnt, done_cnt, done_at;
        reset = 1'b0; start = 1'b0; ALUCtrl = '0; Branch = 1'b0;
        A = '0; B = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_zero", {31'b0, Zero}, 32'd0);
        check("rst_taken", {31'b0, BranchTaken}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset aborts a long shift
        launch(5'b01001, 1'b0, 32'd0, 32'd1, 5'd20);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", Result, 32'd0);
        check("abort_zero", {31'b0, Zero}, 32'd0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);

        // ADD wraps to zero, one cycle
        launch(5'b00010, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("add_done", {31'b0, done}, 32'd1);
        check("add_busy", {31'b0, busy}, 32'd0);
        check("add_res", Result, 32'd0);
        check("add_zero", {31'b0, Zero}, 32'd1);
        @(posedge clk); #1;
        check("add_done_pulse", {31'b0, done}, 32'd0);

        // SRA by 31 with ignored start pulses at edges t+3 and t+10
        launch(5'b01010, 1'b0, 32'd0, 32'h8000_0000, 5'd31);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i <= 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = i; end
            ALUCtrl = 5'b00010; A = 32'd1; B = 32'd1;
            start = (i + 1 == 3 || i + 1 == 10);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("sra_busy_cycles", busy_cnt, 32'd31);
        check("sra_done_count", done_cnt, 32'd1);
        check("sra_done_edge", done_at, 32'd31);
        check("sra_res", Result, 32'hFFFF_FFFF);

        // Overloaded code 01000
        single("slt", 5'b01000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        check("slt_zero", {31'b0, Zero}, 32'd0);
        single("bne", 5'b01000, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check("bne_zero", {31'b0, Zero}, 32'd1);

        // Branch conditions
        single("blez", 5'b01010, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1);
        single("bgtz", 5'b01001, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0);
        single("bgez", 5'b11011, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b0);
        single("bltz", 5'b11111, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
        single("beq", 5'b00110, 1'b1, 32'h1234, 32'h1234, 32'd0, 1'b1);

        // Misc single-cycle ops
        single("xor", 5'b01101, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
        single("sltu", 5'b00111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        single("sub", 5'b00110, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        single("undef", 5'b10001, 1'b1, 32'h55, 32'h55, 32'd0, 1'b0);

        // Back-to-back: SLLV with A[4:0]=0, then SRLV launched in its done cycle
        launch(5'b01110, 1'b0, 32'h20, 32'd5, 5'd0);
        check("sllv_done", {31'b0, done}, 32'd1);
        check("sllv_busy", {31'b0, busy}, 32'd0);
        check("sllv_res", Result, 32'd5);
        launch(5'b10000, 1'b0, 32'd3, 32'h0000_00F0, 5'd0);
        check("srlv_busy", {31'b0, busy}, 32'd1);
        wait_done("srlv", 10, n);
        check("srlv_latency", n, 32'd3);
        check("srlv_res", Result, 32'h0000_001E);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
